// File: rtl/ann_sequencer_if.sv
// Control bundle between the host, the sequencer and the DataPath block.
// The sequencer takes the slave view; the host/bench side takes the master view.
`timescale 1ns/1ps

interface ann_sequencer_if #(
    parameter int OFFSET_W = 3
);
    logic                start;
    logic                abort;
    logic [OFFSET_W-1:0] offset;
    logic                ld;
    logic                read;
    logic                ready;
    logic                busy;
    logic                done;

    modport master (
        output start, abort,
        input  offset, ld, read, ready, busy, done
    );

    modport slave (
        input  start, abort,
        output offset, ld, read, ready, busy, done
    );
endinterface

// File: rtl/ann_sequencer.sv
// Control FSM for the ANN DataPath: load one input vector, then read/accumulate/commit
// each neuron offset in turn, pulsing done at the end of the pass.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for start; all outputs low, offset 0
//   LOAD    | ld high, input vector captured by the datapath
//   READ    | read high, weights fetched for the current offset
//   ACC     | MAC_CYCLES accumulate cycles for the current offset
//   LATCH   | ready high, accumulated value committed; advance offset
//   DONE    | done pulse, back to IDLE
`timescale 1ns/1ps

module ann_sequencer #(
    parameter int OFFSET_W    = 3,
    parameter int NUM_OFFSETS = 8,
    parameter int MAC_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    ann_sequencer_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_ACC   = 3'd3,
        S_LATCH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int MAC_W = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1;
    localparam logic [MAC_W-1:0]    MAC_LAST = MAC_W'(MAC_CYCLES - 1);
    localparam logic [OFFSET_W-1:0] OFS_LAST = OFFSET_W'(NUM_OFFSETS - 1);

    state_t              state_q;
    state_t              state_d;
    logic [MAC_W-1:0]    mac_q;
    logic [OFFSET_W-1:0] ofs_q;
    logic                mac_last;
    logic                ofs_last;

    logic                ld_o;
    logic                read_o;
    logic                ready_o;
    logic                busy_o;
    logic                done_o;

    assign mac_last = (mac_q == MAC_LAST);
    assign ofs_last = (ofs_q == OFS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_READ;
            S_READ:  state_d = S_ACC;
            S_ACC: begin
                if (mac_last) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: state_d = ofs_last ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort overrides every non-idle transition, DONE included
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        ld_o    = 1'b0;
        read_o  = 1'b0;
        ready_o = 1'b0;
        done_o  = 1'b0;
        busy_o  = (state_q != S_IDLE);
        case (state_q)
            S_LOAD:  ld_o    = 1'b1;
            S_READ:  read_o  = 1'b1;
            S_LATCH: ready_o = 1'b1;
            S_DONE:  done_o  = 1'b1;
            default: ;
        endcase
    end

    // MAC counter runs only while staying in ACC, so it is zero on entry from READ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_q <= '0;
        end else if ((state_q == S_ACC) && (state_d == S_ACC)) begin
            mac_q <= mac_q + MAC_W'(1);
        end else begin
            mac_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofs_q <= '0;
        end else if (state_d == S_IDLE) begin
            ofs_q <= '0;
        end else if ((state_q == S_LATCH) && (state_d == S_READ)) begin
            ofs_q <= ofs_q + OFFSET_W'(1);
        end
    end

    assign bus.offset = ofs_q;
    assign bus.ld     = ld_o;
    assign bus.read   = read_o;
    assign bus.ready  = ready_o;
    assign bus.busy   = busy_o;
    assign bus.done   = done_o;

endmodule

// File: tb/tb_ann_sequencer.sv
// Scoreboard bench for ann_sequencer: expected output vectors are queued from a
// timing model when a pass is launched and compared cycle by cycle.
`timescale 1ns/1ps

module tb_ann_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ann_sequencer_if #(.OFFSET_W(3)) if_d ();
    ann_sequencer_if #(.OFFSET_W(3)) if_s ();

    ann_sequencer #(.OFFSET_W(3), .NUM_OFFSETS(8), .MAC_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (if_d)
    );

    ann_sequencer #(.OFFSET_W(3), .NUM_OFFSETS(1), .MAC_CYCLES(1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (if_s)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];

    // vector layout: busy, done, ready, read, ld, offset[2:0]
    function automatic logic [7:0] obs_d();
        return {if_d.busy, if_d.done, if_d.ready, if_d.read, if_d.ld, if_d.offset};
    endfunction

    function automatic logic [7:0] obs_s();
        return {if_s.busy, if_s.done, if_s.ready, if_s.read, if_s.ld, if_s.offset};
    endfunction

    // expected outputs in cycle n of a pass (cycle 1 = LOAD), from the timing formulas
    function automatic logic [7:0] model(int n, int nofs, int mac);
        int         d;
        int         k;
        int         p;
        int         last;
        logic [7:0] e;
        d    = 2 + nofs * (mac + 2);
        last = nofs - 1;
        e    = 8'h00;
        if (n == 1) begin
            e[7] = 1'b1;
            e[3] = 1'b1;
        end else if (n >= 2 && n < d) begin
            k = (n - 2) / (mac + 2);
            p = (n - 2) % (mac + 2);
            e[7]   = 1'b1;
            e[2:0] = k[2:0];
            if (p == 0)            e[4] = 1'b1;
            else if (p == mac + 1) e[5] = 1'b1;
        end else if (n == d) begin
            e[7]   = 1'b1;
            e[6]   = 1'b1;
            e[2:0] = last[2:0];
        end
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        logic [7:0] e;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_d.start = i[0];
            if_s.start = i[0];
            exp_q.push_back(8'h00);
            @(negedge clk);
            o = obs_d();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, o, e);
            end
            o = obs_s();
            n_checks++;
            if (o !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold_small cycle %0d: got %b expected %b", i, o, 8'h00);
            end
        end
        if_d.start = 1'b0;
        if_s.start = 1'b0;
        #2 rst = 1'b1;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h00);
            @(negedge clk);
            o = obs_d();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_release cycle %0d: got %b expected %b", i, o, e);
            end
            next_cycle();
        end
    endtask

    task automatic test_full_pass(input int repulse_at);
        logic [7:0] o;
        logic [7:0] e;
        int         ready_cnt;
        ready_cnt = 0;
        for (int n = 1; n <= 52; n++) exp_q.push_back(model(n, 8, 4));
        if_d.start = 1'b1;
        next_cycle();
        if_d.start = 1'b0;
        for (int n = 1; n <= 52; n++) begin
            @(negedge clk);
            o = obs_d();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL full_pass cycle %0d: got %b expected %b", n, o, e);
            end
            n_checks++;
            if ($countones(o[6:3]) > 1) begin
                n_fail++;
                $display("FAIL strobe_exclusive cycle %0d: got %b expected at most one strobe", n, o[6:3]);
            end
            if (o[5] === 1'b1) ready_cnt++;
            next_cycle();
            if_d.start = (n + 1 == repulse_at);
        end
        n_checks++;
        if (ready_cnt != 8) begin
            n_fail++;
            $display("FAIL ready_count: got %0d expected %0d", ready_cnt, 8);
        end
    endtask

    task automatic test_small_params();
        logic [7:0] o;
        logic [7:0] e;
        for (int n = 1; n <= 7; n++) exp_q.push_back(model(n, 1, 1));
        if_s.start = 1'b1;
        next_cycle();
        if_s.start = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            o = obs_s();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL small_pass cycle %0d: got %b expected %b", n, o, e);
            end
            next_cycle();
        end
    endtask

    task automatic test_abort();
        logic [7:0] o;
        logic [7:0] e;
        // abort high during cycle 22 (ACC of offset 3)
        for (int n = 1; n <= 26; n++) exp_q.push_back((n <= 22) ? model(n, 8, 4) : 8'h00);
        if_d.start = 1'b1;
        next_cycle();
        if_d.start = 1'b0;
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            o = obs_d();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_pass cycle %0d: got %b expected %b", n, o, e);
            end
            next_cycle();
            if_d.abort = (n + 1 == 22);
        end
        test_full_pass(0);
    endtask

    task automatic test_start_with_abort();
        logic [7:0] o;
        logic [7:0] e;
        if_d.start = 1'b1;
        if_d.abort = 1'b1;
        for (int n = 0; n < 3; n++) exp_q.push_back(8'h00);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            o = obs_d();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL start_abort_idle cycle %0d: got %b expected %b", n, o, e);
            end
            next_cycle();
            if_d.start = 1'b0;
            if_d.abort = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] o;
        logic [7:0] e;
        for (int n = 1; n <= 63; n++) begin
            if (n <= 50)      exp_q.push_back(model(n, 8, 4));
            else if (n == 51) exp_q.push_back(8'h00);
            else if (n <= 61) exp_q.push_back(model(n - 51, 8, 4));
            else              exp_q.push_back(8'h00);
        end
        if_d.start = 1'b1;
        next_cycle();
        for (int n = 1; n <= 63; n++) begin
            @(negedge clk);
            o = obs_d();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", n, o, e);
            end
            next_cycle();
            if (n + 1 == 61) begin
                if_d.start = 1'b0;
                if_d.abort = 1'b1;
            end else begin
                if_d.abort = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] o;
        logic [7:0] e;
        for (int n = 1; n <= 30; n++) exp_q.push_back(model(n, 8, 4));
        if_d.start = 1'b1;
        next_cycle();
        if_d.start = 1'b0;
        for (int n = 1; n <= 29; n++) begin
            @(negedge clk);
            o = obs_d();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_pre cycle %0d: got %b expected %b", n, o, e);
            end
            next_cycle();
        end
        #1;
        o = obs_d();
        e = exp_q.pop_front();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL async_cycle30: got %b expected %b", o, e);
        end
        #1 rst = 1'b0;
        #1;
        o = obs_d();
        n_checks++;
        if (o !== 8'h00) begin
            n_fail++;
            $display("FAIL async_drop: got %b expected %b", o, 8'h00);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = obs_d();
        n_checks++;
        if (o !== 8'h00) begin
            n_fail++;
            $display("FAIL async_held: got %b expected %b", o, 8'h00);
        end
        #2 rst = 1'b1;
        next_cycle();
        for (int n = 0; n < 3; n++) exp_q.push_back(8'h00);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            o = obs_d();
            e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_idle_wait cycle %0d: got %b expected %b", n, o, e);
            end
            next_cycle();
        end
        test_full_pass(0);
    endtask

    initial begin
        rst        = 1'b0;
        if_d.start = 1'b0;
        if_d.abort = 1'b0;
        if_s.start = 1'b0;
        if_s.abort = 1'b0;
        test_reset();
        test_full_pass(0);
        test_small_params();
        test_abort();
        test_full_pass(20);
        test_start_with_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
